// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the odd-even transposition sorter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sort_pkg;

    localparam int SORT_DATA_WIDTH = 8;
    localparam int SORT_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } sort_state_t;

endpackage

// File: rtl/sort_if.sv
// Bundles the sorter's data arrays for the block that drives the sorter and
// observes its result.
// Latency: n/a (wiring only). Backpressure: none, there is no handshake.
// Modports: master drives unsorted_array and reads sorted_array; slave is the sorter side.
interface sort_if
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = SORT_DATA_WIDTH,
    parameter int ADDR_WIDTH = SORT_ADDR_WIDTH
);
    localparam int N = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] unsorted_array [N-1:0];
    logic [DATA_WIDTH-1:0] sorted_array   [N-1:0];

    modport master (output unsorted_array, input  sorted_array);
    modport slave  (input  unsorted_array, output sorted_array);

endinterface

// File: rtl/sort_cmp_swap.sv
// Compare-exchange cell: orders one pair of unsigned values.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b in; lo = min(a,b), hi = max(a,b). Equal inputs pass straight through.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = SORT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    logic swap;

    // Strictly greater: equal values never swap, which keeps the sort stable.
    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_top.sv
// Odd-even transposition sorter over N = 2**ADDR_WIDTH unsigned elements.
// Latency: result registered N+1 cycles after the capture edge (17 at defaults).
// Backpressure: none; the captured input is sorted once, then the result is held until reset.
// Ports: clk, reset (sync, active-high), unsorted_array in, sorted_array out (index 0 = smallest).
module sort_top
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = SORT_DATA_WIDTH,
    parameter int ADDR_WIDTH = SORT_ADDR_WIDTH,
    localparam int N = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] unsorted_array [N-1:0],
    output logic [DATA_WIDTH-1:0] sorted_array   [N-1:0]
);

    localparam logic [ADDR_WIDTH:0] PHASE_END = (ADDR_WIDTH + 1)'(N);

    sort_state_t           state;
    logic [ADDR_WIDTH:0]   phase_cnt;
    logic [DATA_WIDTH-1:0] work     [N-1:0];
    logic [DATA_WIDTH-1:0] work_nxt [N-1:0];
    logic [DATA_WIDTH-1:0] pair_lo  [N-2:0];
    logic [DATA_WIDTH-1:0] pair_hi  [N-2:0];

    // One cell per adjacent pair; phase parity decides which cells take effect.
    for (genvar i = 0; i < N - 1; i++) begin : g_cmp
        sort_cmp_swap #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cmp (
            .a  (work[i]),
            .b  (work[i+1]),
            .lo (pair_lo[i]),
            .hi (pair_hi[i])
        );
    end

    // Pair (i,i+1) is active when i has the same parity as the phase counter,
    // so even phases use (0,1),(2,3).. and odd phases use (1,2),(3,4)..
    // Active pairs never overlap, so each element has at most one writer.
    always_comb begin
        work_nxt = work;
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == phase_cnt[0]) begin
                work_nxt[i]   = pair_lo[i];
                work_nxt[i+1] = pair_hi[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            phase_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                work[i]         <= '0;
                sorted_array[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    work      <= unsorted_array;
                    phase_cnt <= '0;
                    state     <= SORT;
                end
                SORT: begin
                    // N phases are enough for odd-even transposition to fully sort N items.
                    if (phase_cnt == PHASE_END) begin
                        sorted_array <= work;
                        state        <= DONE;
                    end else begin
                        work      <= work_nxt;
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Terminal: hold everything until reset.
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_top.sv
module tb_sort_top;
    import sort_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;
    localparam int VW = N * DW;

    typedef logic [DW-1:0] vec_t [16];

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sort_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

    sort_top #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .unsorted_array (sif.unsorted_array),
        .sorted_array   (sif.sorted_array)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_vec(input vec_t v);
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i];
        return r;
    endfunction

    function automatic logic [VW-1:0] out_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = sif.sorted_array[i];
        return r;
    endfunction

    task automatic drive(input vec_t v);
        for (int i = 0; i < N; i++) sif.unsorted_array[i] = v[i];
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) sif.unsorted_array[i] = DW'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset edge, then E0..E16 must show zeros, then E17 must show the result.
    task automatic run_sort(input string tag, input vec_t v, input vec_t exp, input bit mess);
        drive(v);
        reset = 1'b1;
        step();
        check({tag, "_rst"}, out_vec(), '0);
        reset = 1'b0;
        for (int k = 0; k <= N; k++) begin
            step();
            if (k == 0 && mess) scramble();
            check($sformatf("%s_zero_e%0d", tag, k), out_vec(), '0);
        end
        step();
        check({tag, "_result"}, out_vec(), pack_vec(exp));
    endtask

    vec_t v_basic, e_basic, v_desc, e_desc, v_dup, e_dup;

    initial begin
        v_basic = '{5, 3, 8, 6, 2, 4, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        e_basic = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < N; i++) begin
            v_desc[i] = DW'(255 - i);
            e_desc[i] = DW'(240 + i);
        end
        v_dup = '{9, 9, 1, 1, 200, 128, 127, 255, 0, 128, 50, 7, 127, 3, 9, 64};
        e_dup = '{0, 1, 1, 3, 7, 9, 9, 9, 50, 64, 127, 127, 128, 128, 200, 255};

        reset = 1'b1;
        drive(v_basic);

        run_sort("basic", v_basic, e_basic, 1'b0);
        run_sort("desc",  v_desc,  e_desc,  1'b0);
        // Inputs are randomised right after the capture edge and must be ignored.
        run_sort("dup",   v_dup,   e_dup,   1'b1);

        // Result must hold in DONE while inputs keep changing.
        for (int k = 0; k < 12; k++) begin
            scramble();
            step();
            check($sformatf("hold_c%0d", k), out_vec(), pack_vec(e_dup));
        end

        // Abort at cycle 8 of SORT, then sort a fresh set.
        drive(v_desc);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int k = 0; k < 8; k++) step();
        reset = 1'b1;
        step();
        check("abort_zero", out_vec(), '0);
        run_sort("after_abort", v_basic, e_basic, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
